// File: rtl/plru_tree_array.sv
// Per-set tree pseudo-LRU store with registered victim selection
// and a one-set-per-cycle flush sweep.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   acc_valid    mark acc_way of acc_set most-recently-used
//   acc_set      set index of the update
//   acc_way      way hit or filled
//   vic_req      victim query request
//   vic_set      set index of the query
//   vic_inv_mask 1 = way currently invalid in vic_set
//   vic_valid    vic_way valid, one cycle after vic_req
//   vic_way      selected victim way (holds when vic_valid=0)
//   flush_req    start a sweep clearing every tree
//   busy         flush sweep in progress
module plru_tree_array #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_valid,
  input  logic [$clog2(SETS)-1:0]   acc_set,
  input  logic [$clog2(WAYS)-1:0]   acc_way,
  input  logic                      vic_req,
  input  logic [$clog2(SETS)-1:0]   vic_set,
  input  logic [WAYS-1:0]           vic_inv_mask,
  output logic                      vic_valid,
  output logic [$clog2(WAYS)-1:0]   vic_way,
  input  logic                      flush_req,
  output logic                      busy
);

  localparam int SW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int NB = WAYS - 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Heap-ordered tree; a node bit of 1 means its upper half is LRU.
  function automatic logic [NB-1:0] tree_upd(
    input logic [NB-1:0] t,
    input logic [WW-1:0] w
  );
    logic [NB-1:0] r;
    int n;
    r = t;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      r[n] = ~w[WW-1-l];
      n = 2 * n + 1 + int'(w[WW-1-l]);
    end
    return r;
  endfunction

  // Invalid ways win, lowest index first; otherwise follow the tree.
  function automatic logic [WW-1:0] vic_pick(
    input logic [NB-1:0]   t,
    input logic [WAYS-1:0] m
  );
    logic [WW-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      v[WW-1-l] = t[n];
      n = 2 * n + 1 + int'(t[n]);
    end
    if (|m) begin
      for (int i = WAYS - 1; i >= 0; i--) begin
        if (m[i]) v = WW'(i);
      end
    end
    return v;
  endfunction

  logic [NB-1:0] tree_q [SETS];
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] ctr_q, ctr_d;
  logic          vic_valid_q, vic_valid_d;
  logic [WW-1:0] vic_way_q, vic_way_d;

  logic          busy_w;
  logic          acc_ok;
  logic          vic_ok;
  logic [NB-1:0] acc_tree;
  logic [NB-1:0] vic_tree;
  logic          we;
  logic [SW-1:0] wa;
  logic [NB-1:0] wd;

  assign busy_w   = (state_q == FLUSH);
  assign acc_ok   = acc_valid & ~busy_w;
  assign vic_ok   = vic_req & ~busy_w;
  assign acc_tree = tree_upd(tree_q[acc_set], acc_way);

  // Same-set update in this cycle is forwarded into the query.
  assign vic_tree = (acc_ok && (acc_set == vic_set))
                  ? acc_tree : tree_q[vic_set];

  // Single write port: sweep owns it while busy.
  always_comb begin
    we = 1'b0;
    wa = acc_set;
    wd = acc_tree;
    if (busy_w) begin
      we = 1'b1;
      wa = ctr_q;
      wd = '0;
    end else if (acc_ok) begin
      we = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          ctr_d   = '0;
        end
      end
      FLUSH: begin
        ctr_d = ctr_q + SW'(1);
        if (ctr_q == SW'(SETS - 1)) begin
          state_d = IDLE;
          ctr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  always_comb begin
    vic_valid_d = vic_ok;
    vic_way_d   = vic_way_q;
    if (vic_ok) vic_way_d = vic_pick(vic_tree, vic_inv_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SETS; i++) tree_q[i] <= '0;
      state_q     <= IDLE;
      ctr_q       <= '0;
      vic_valid_q <= 1'b0;
      vic_way_q   <= '0;
    end else begin
      if (we) tree_q[wa] <= wd;
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      vic_valid_q <= vic_valid_d;
      vic_way_q   <= vic_way_d;
    end
  end

  assign vic_valid = vic_valid_q;
  assign vic_way   = vic_way_q;
  assign busy      = busy_w;

endmodule

// File: tb/tb_plru_tree_array.sv
// Directed bench for plru_tree_array (WAYS=4, SETS=16).
// Each task drives one scenario and checks inline.
module tb_plru_tree_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       acc_valid = 1'b0;
  logic [3:0] acc_set = '0;
  logic [1:0] acc_way = '0;
  logic       vic_req = 1'b0;
  logic [3:0] vic_set = '0;
  logic [3:0] vic_inv_mask = '0;
  logic       vic_valid;
  logic [1:0] vic_way;
  logic       flush_req = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  plru_tree_array #(.WAYS(4), .SETS(16)) dut (
    .clk(clk),
    .rst(rst),
    .acc_valid(acc_valid),
    .acc_set(acc_set),
    .acc_way(acc_way),
    .vic_req(vic_req),
    .vic_set(vic_set),
    .vic_inv_mask(vic_inv_mask),
    .vic_valid(vic_valid),
    .vic_way(vic_way),
    .flush_req(flush_req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_acc(input logic [3:0] s, input logic [1:0] w);
    acc_valid = 1'b1;
    acc_set = s;
    acc_way = w;
    step();
    acc_valid = 1'b0;
  endtask

  task automatic do_vic(input logic [3:0] s, input logic [3:0] m);
    vic_req = 1'b1;
    vic_set = s;
    vic_inv_mask = m;
    step();
    vic_req = 1'b0;
    vic_inv_mask = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    n_chk++;
    if (vic_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vvalid: got %b want 0", vic_valid);
    end
    n_chk++;
    if (vic_way !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_vway: got %0d want 0", vic_way);
    end
  endtask

  task automatic test_first_query();
    do_vic(4'd3, 4'b0000);
    n_chk++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
      n_fail++;
      $display("FAIL q3: got v=%b w=%0d want v=1 w=0",
               vic_valid, vic_way);
    end
    step();
    n_chk++;
    if (vic_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL q3_idle: got v=%b want 0", vic_valid);
    end
  endtask

  task automatic test_update_seq();
    logic [1:0] ways [3];
    logic [1:0] exps [3];
    ways = '{2'd0, 2'd2, 2'd1};
    exps = '{2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      do_acc(4'd5, ways[i]);
      do_vic(4'd5, 4'b0000);
      n_chk++;
      if (vic_valid !== 1'b1 || vic_way !== exps[i]) begin
        n_fail++;
        $display("FAIL seq5_%0d: got v=%b w=%0d want v=1 w=%0d",
                 i, vic_valid, vic_way, exps[i]);
      end
    end
    step();
    n_chk++;
    if (vic_valid !== 1'b0 || vic_way !== 2'd3) begin
      n_fail++;
      $display("FAIL hold: got v=%b w=%0d want v=0 w=3",
               vic_valid, vic_way);
    end
    do_vic(4'd6, 4'b0000);
    n_chk++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
      n_fail++;
      $display("FAIL set6: got v=%b w=%0d want v=1 w=0",
               vic_valid, vic_way);
    end
  endtask

  task automatic test_forward();
    logic [3:0] qs [2];
    logic [1:0] exps [2];
    qs = '{4'd7, 4'd8};
    exps = '{2'd2, 2'd0};
    for (int i = 0; i < 2; i++) begin
      acc_valid = 1'b1;
      acc_set = 4'd7;
      acc_way = 2'd0;
      vic_req = 1'b1;
      vic_set = qs[i];
      vic_inv_mask = '0;
      step();
      acc_valid = 1'b0;
      vic_req = 1'b0;
      n_chk++;
      if (vic_valid !== 1'b1 || vic_way !== exps[i]) begin
        n_fail++;
        $display("FAIL fwd_%0d: got v=%b w=%0d want v=1 w=%0d",
                 qs[i], vic_valid, vic_way, exps[i]);
      end
    end
    do_vic(4'd7, 4'b0000);
    n_chk++;
    if (vic_way !== 2'd2) begin
      n_fail++;
      $display("FAIL set7_after: got %0d want 2", vic_way);
    end
  endtask

  task automatic test_inv_mask();
    logic [3:0] ms [4];
    logic [1:0] exps [4];
    ms = '{4'b1010, 4'b0000, 4'b1000, 4'b1111};
    exps = '{2'd1, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      do_vic(4'd5, ms[i]);
      n_chk++;
      if (vic_valid !== 1'b1 || vic_way !== exps[i]) begin
        n_fail++;
        $display("FAIL mask_%b: got v=%b w=%0d want v=1 w=%0d",
                 ms[i], vic_valid, vic_way, exps[i]);
      end
    end
  endtask

  task automatic test_flush();
    int cnt;
    logic [3:0] qs [3];
    qs = '{4'd0, 4'd15, 4'd3};
    do_acc(4'd0, 2'd0);
    do_acc(4'd15, 2'd0);
    flush_req = 1'b1;
    acc_valid = 1'b1;
    acc_set = 4'd3;
    acc_way = 2'd0;
    vic_req = 1'b1;
    vic_set = 4'd3;
    vic_inv_mask = '0;
    step();
    flush_req = 1'b0;
    acc_valid = 1'b0;
    vic_req = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || vic_valid !== 1'b1 || vic_way !== 2'd2) begin
      n_fail++;
      $display("FAIL fl_start: got b=%b v=%b w=%0d want b=1 v=1 w=2",
               busy, vic_valid, vic_way);
    end
    cnt = 1;
    while (busy === 1'b1 && cnt < 40) begin
      acc_valid = 1'b1;
      acc_set = 4'd0;
      acc_way = 2'd1;
      vic_req = 1'b1;
      vic_set = 4'd0;
      flush_req = 1'b1;
      step();
      n_chk++;
      if (vic_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fl_vvalid: got %b want 0 at %0d",
                 vic_valid, cnt);
      end
      if (busy === 1'b1) cnt++;
    end
    acc_valid = 1'b0;
    vic_req = 1'b0;
    flush_req = 1'b0;
    n_chk++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL fl_len: got %0d want 16", cnt);
    end
    step();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_rearm: got %b want 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      do_vic(qs[i], 4'b0000);
      n_chk++;
      if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
        n_fail++;
        $display("FAIL fl_set%0d: got v=%b w=%0d want v=1 w=0",
                 qs[i], vic_valid, vic_way);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    do_acc(4'd2, 2'd0);
    do_acc(4'd10, 2'd0);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    step();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mf_busy4: got %b want 1", busy);
    end
    rst = 1'b0;
    vic_req = 1'b1;
    vic_set = 4'd10;
    step();
    rst = 1'b1;
    vic_req = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || vic_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mf_rst: got b=%b v=%b want b=0 v=0",
               busy, vic_valid);
    end
    for (int s = 0; s < 16; s++) begin
      do_vic(4'(s), 4'b0000);
      n_chk++;
      if (vic_valid !== 1'b1 || vic_way !== 2'd0) begin
        n_fail++;
        $display("FAIL mf_set%0d: got v=%b w=%0d want v=1 w=0",
                 s, vic_valid, vic_way);
      end
    end
    acc_valid = 1'b1;
    acc_set = 4'd2;
    acc_way = 2'd0;
    vic_req = 1'b1;
    vic_set = 4'd2;
    step();
    acc_valid = 1'b0;
    vic_req = 1'b0;
    n_chk++;
    if (vic_valid !== 1'b1 || vic_way !== 2'd2) begin
      n_fail++;
      $display("FAIL mf_new: got v=%b w=%0d want v=1 w=2",
               vic_valid, vic_way);
    end
  endtask

  initial begin
    test_reset();
    test_first_query();
    test_update_seq();
    test_forward();
    test_inv_mask();
    test_flush();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
